// File: rtl/prescaled_down_timer_pkg.sv
// Shared types and helpers for the prescaled countdown timer.
package prescaled_down_timer_pkg;

    // Controller phases: waiting for a load, counting down, signalling expiry.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Terminal prescaler value for a given prescaler width (all ones).
    function automatic int unsigned prescale_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage : prescaled_down_timer_pkg

// File: rtl/prescaled_down_timer_comb.sv
// Next-state and output decode for the prescaled countdown timer.
// Purely combinational; the top owns every register.
module prescaled_down_timer_comb
    import prescaled_down_timer_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 2,
    parameter int COUNT_WIDTH    = 3
) (
    input  state_t                   state_i,
    input  logic [PRESCALE_WIDTH-1:0] x_i,
    input  logic [COUNT_WIDTH-1:0]    y_i,
    input  logic                     hold_i,
    input  logic                     load_valid_i,
    input  logic [COUNT_WIDTH-1:0]    load_count_i,
    output state_t                   state_d_o,
    output logic [PRESCALE_WIDTH-1:0] x_d_o,
    output logic [COUNT_WIDTH-1:0]    y_d_o,
    output logic                     load_ready_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_MAX =
        PRESCALE_WIDTH'(prescale_max(PRESCALE_WIDTH));
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

    // Next-state computation for the controller, prescaler and major count.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // one unassigned; an unassigned path would infer a latch.
        state_d_o = state_i;
        x_d_o     = x_i;
        y_d_o     = y_i;

        unique case (state_i)
            IDLE: begin
                if (load_valid_i) begin
                    if (load_count_i != '0) begin
                        y_d_o     = load_count_i;
                        x_d_o     = '0;
                        state_d_o = RUN;
                    end else begin
                        // A zero count expires immediately; x and y are already 0.
                        state_d_o = DONE;
                    end
                end
            end
            RUN: begin
                if (!hold_i) begin
                    x_d_o = x_i + 1'b1;
                    if (x_i == PRESCALE_MAX) begin
                        y_d_o = y_i - COUNT_ONE;
                        // Leaving at y==1 guarantees y never wraps below zero.
                        if (y_i == COUNT_ONE) begin
                            state_d_o = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_d_o = IDLE;
            end
            default: begin
                state_d_o = IDLE;
            end
        endcase
    end

    // Status outputs depend on the registered state only.
    always_comb begin
        load_ready_o = (state_i == IDLE);
        busy_o       = (state_i == RUN);
        done_o       = (state_i == DONE);
    end

endmodule : prescaled_down_timer_comb

// File: rtl/prescaled_down_timer.sv
// Prescaled countdown timer: a valid/ready load arms the major count, which
// decrements once per prescaler wrap; expiry raises a one-cycle done pulse.
module prescaled_down_timer
    import prescaled_down_timer_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 2,
    parameter int COUNT_WIDTH    = 3
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   load_valid,
    input  logic [COUNT_WIDTH-1:0] load_count,
    output logic                   load_ready,
    input  logic                   hold,
    output logic [COUNT_WIDTH-1:0] O,
    output logic                   busy,
    output logic                   done
);

    state_t                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] x_q, x_d;
    logic [COUNT_WIDTH-1:0]    y_q, y_d;

    prescaled_down_timer_comb #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH),
        .COUNT_WIDTH    (COUNT_WIDTH)
    ) u_comb (
        .state_i      (state_q),
        .x_i          (x_q),
        .y_i          (y_q),
        .hold_i       (hold),
        .load_valid_i (load_valid),
        .load_count_i (load_count),
        .state_d_o    (state_d),
        .x_d_o        (x_d),
        .y_d_o        (y_d),
        .load_ready_o (load_ready),
        .busy_o       (busy),
        .done_o       (done)
    );

    // State, prescaler and major-count registers with synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (RESET) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // The visible count is the major count register in every state.
    always_comb begin
        O = y_q;
    end

endmodule : prescaled_down_timer

// File: tb/tb_prescaled_down_timer.sv
// Self-checking bench for prescaled_down_timer: a cycle-level reference model
// based on remaining running cycles feeds a scoreboard queue that a separate
// monitor drains on the falling edge.
module tb_prescaled_down_timer;

    localparam int PW     = 2;
    localparam int CW     = 3;
    localparam int PERIOD = 1 << PW;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          load_valid;
    logic [CW-1:0] load_count;
    logic          load_ready;
    logic          hold;
    logic [CW-1:0] O;
    logic          busy;
    logic          done;

    prescaled_down_timer #(
        .PRESCALE_WIDTH (PW),
        .COUNT_WIDTH    (CW)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .load_valid (load_valid),
        .load_count (load_count),
        .load_ready (load_ready),
        .hold       (hold),
        .O          (O),
        .busy       (busy),
        .done       (done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [CW-1:0] o;
        logic          busy;
        logic          done;
        logic          ready;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: phase plus number of un-held running cycles left.
    localparam int P_IDLE    = 0;
    localparam int P_COUNT   = 1;
    localparam int P_EXPIRED = 2;
    int m_phase = P_IDLE;
    int m_rem   = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time,
                     actual, expected);
        end
    endtask

    // Advance the model by one clock edge with the given inputs and record
    // the outputs expected after that edge.
    task automatic model_edge(input logic rst, input logic lv,
                              input logic [CW-1:0] lc, input logic hd);
        exp_t e;
        if (rst) begin
            m_phase = P_IDLE;
            m_rem   = 0;
        end else begin
            case (m_phase)
                P_IDLE: begin
                    if (lv) begin
                        if (lc == 0) begin
                            m_phase = P_EXPIRED;
                        end else begin
                            m_phase = P_COUNT;
                            m_rem   = int'(lc) * PERIOD;
                        end
                    end
                end
                P_COUNT: begin
                    if (!hd) begin
                        m_rem--;
                        if (m_rem == 0) m_phase = P_EXPIRED;
                    end
                end
                default: m_phase = P_IDLE;
            endcase
        end
        // Major count = whole prescale periods still outstanding, rounded up.
        e.o     = (m_phase == P_COUNT) ? CW'((m_rem + PERIOD - 1) / PERIOD) : '0;
        e.busy  = (m_phase == P_COUNT);
        e.done  = (m_phase == P_EXPIRED);
        e.ready = (m_phase == P_IDLE);
        exp_q.push_back(e);
    endtask

    task automatic step(input logic rst, input logic lv,
                        input logic [CW-1:0] lc, input logic hd);
        RESET      = rst;
        load_valid = lv;
        load_count = lc;
        hold       = hd;
        model_edge(rst, lv, lc, hd);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0);
    endtask

    // Monitor: compare the DUT outputs against each queued expectation.
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("O",          32'(O),          32'(e.o));
            check("busy",       32'(busy),       32'(e.busy));
            check("done",       32'(done),       32'(e.done));
            check("load_ready", 32'(load_ready), 32'(e.ready));
        end
    end

    initial begin
        RESET      = 1'b1;
        load_valid = 1'b0;
        load_count = '0;
        hold       = 1'b0;
        #1;

        // Reset for two cycles, then idle with no requests.
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        idle_cycles(20);

        // Basic countdown from 3.
        step(1'b0, 1'b1, 3'd3, 1'b0);
        idle_cycles(16);

        // Zero load expires immediately.
        step(1'b0, 1'b1, 3'd0, 1'b0);
        idle_cycles(3);

        // Load 2 with hold asserted at edges E0+3..E0+7.
        step(1'b0, 1'b1, 3'd2, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, 1'b0, '0, (k >= 3 && k <= 7));
        end

        // Load 7; a second request at E0+5 must be ignored.
        step(1'b0, 1'b1, 3'd7, 1'b0);
        for (int k = 1; k <= 31; k++) begin
            if (k == 5) step(1'b0, 1'b1, 3'd1, 1'b0);
            else        step(1'b0, 1'b0, '0, 1'b0);
        end

        // Load 5, reset at E0+9, then idle.
        step(1'b0, 1'b1, 3'd5, 1'b0);
        for (int k = 1; k <= 8; k++) step(1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        idle_cycles(25);

        // Randomised traffic: loads, holds and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) == 0),
                 CW'($urandom_range(0, (1 << CW) - 1)),
                 ($urandom_range(0, 4) == 0));
        end

        @(negedge CLK);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_prescaled_down_timer

// File: doc/prescaled_down_timer.md
# prescaled_down_timer

Prescaled countdown timer, the decrementing counterpart of the team's prescaled up-counter. A 2-bit prescaler advances every cycle, and the 3-bit major count decrements once per prescaler wrap. The major count is loaded through a valid/ready handshake, and the block signals expiry with a one-cycle `done` pulse. It sits beside the up-counter in timing and sequencing logic, where software or an FSM arms a delay and waits for expiry.

## Interface
Parameters:
- `PRESCALE_WIDTH`, default 2: prescaler width; one major decrement every 2^PRESCALE_WIDTH running cycles.
- `COUNT_WIDTH`, default 3: major count width.

Ports:
- `CLK`  in  1: clock; all state updates on the rising edge.
- `RESET`  in  1: reset, synchronous and active-high.
- `load_valid`  in  1: a load request is present.
- `load_count`  in  COUNT_WIDTH: major count to load; sampled when `load_valid && load_ready`.
- `load_ready`  out  1: block can accept a load (IDLE only).
- `hold`  in  1: freezes the prescaler and major count while RUN.
- `O`  out  COUNT_WIDTH: current major count.
- `busy`  out  1: high in RUN.
- `done`  out  1: one-cycle expiry pulse.

## Operation
- State machine:
  - IDLE: `load_ready`=1.
    - On handshake with `load_count`=N≠0: `y`<=N, `x`<=0, go to RUN.
    - On handshake with N=0: go directly to DONE; `y`, `x` stay 0.
  - RUN: `busy`=1, `load_ready`=0, `load_valid` ignored.
    - If `hold`=0: `x`<=`x`+1 (modulo 2^PRESCALE_WIDTH).
    - When `x`==2^PRESCALE_WIDTH−1 and `hold`=0: `y`<=`y`−1.
    - If additionally `y`==1: `y`<=0 and go to DONE.
    - If `hold`=1: `x` and `y` are unchanged.
  - DONE: `done`=1, `load_ready`=0, `busy`=0; unconditional transition to IDLE on the next edge.
- Outputs:
  - `O`=`y` in all states.
  - `busy`, `done` and `load_ready` decode from state only; there is no input-to-output combinational path.
- Arithmetic: unsigned, wrap-free by construction; `y` never decrements below 0, because leaving RUN happens at `y`==1.
- `hold` has no effect in IDLE or DONE.

## Timing
- Reset: after any edge with `RESET`=1:
  - state=IDLE, `x`=0, `y`=0;
  - `O`=0, `busy`=0, `done`=0, `load_ready`=1.
- `RESET` has priority over all other inputs in every state, including mid-RUN and DONE; the `done` pulse is suppressed if reset coincides with DONE.
- Latency: handshake at edge E0 with count N and no `hold` → `done` high during the single cycle after edge E0 + N·2^PRESCALE_WIDTH. This covers N=0, where `done` is high in the cycle after E0.
- Each cycle of `hold`=1 in RUN extends the latency by exactly one cycle.
- `load_ready` returns to 1 in the cycle after `done`. Back-to-back loads are therefore spaced N·2^P+2 cycles apart.
- `O` changes only on the decrement edge, or on the load edge when N≠0.

## Structure
- Shared package `prescaled_down_timer_pkg`:
  - state enum {IDLE, RUN, DONE};
  - `PRESCALE_MAX` = 2^PRESCALE_WIDTH−1 as a localparam function of the parameter.
- Natural split: the top holds the state, `x` and `y` registers. Sub-module `prescaled_down_timer_comb` is purely combinational and computes:
  - inputs: current state, `x`, `y`, `hold`, `load_valid`, `load_count`;
  - outputs: next state/`x`/`y` and the output decodes.

## Test plan
- Reset then idle: assert `RESET` 2 cycles → `O`=0, `busy`=0, `done`=0, `load_ready`=1. Hold `load_valid`=0 for 20 cycles → outputs stay unchanged.
- Basic countdown: load N=3 at edge E0 → `busy`=1 from E0+1.
  - `O` reads 3,2,1,0, changing at E0+4, E0+8 and E0+12.
  - `done`=1 only in the cycle after E0+12.
  - `load_ready`=1 after E0+13.
- Zero load: load N=0 → `done`=1 in the next cycle, `busy` never 1, `O`=0, `load_ready`=1 one cycle later.
- Hold: load N=2, assert `hold` for 5 cycles starting at E0+3 → `O` frozen at 2 throughout the hold, and `done` arrives in the cycle after E0+13 instead of E0+8.
- Load ignored while busy: load N=7, then at E0+5 drive `load_valid`=1 with `load_count`=1 → `load_ready`=0, no effect, and `done` at E0+28 as for N=7.
- Reset mid-operation: load N=5, assert `RESET` at E0+9 → IDLE, `O`=0, `busy`=0, `load_ready`=1 the following cycle, and no `done` pulse ever appears.
